phase_accumulator: RTL and testbench

PHASE_ACCUMULATOR -- requirements
Module: phase_accumulator

---
 rtl/phase_accumulator.sv | 111 +++++++++++
 tb/tb_phase_accumulator.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/phase_accumulator.sv
// Phase accumulator for the sinusoid synth: adds a clamped per-sample increment
// to a 16Q.16N phase that is kept wrapped into [-PI_Q, PI_Q), with hard sync.
module phase_accumulator #(
    parameter int PI_Q     = 205887,
    parameter int TWO_PI_Q = 411774
) (
    input  logic               Sys_clk,
    input  logic               Phs_rst,
    input  logic               Phs_ce,
    input  logic signed [31:0] Freq,
    input  logic               Freq_ld,
    input  logic               Sync,
    output logic signed [31:0] Phase,
    output logic               Phase_vld,
    output logic               Cycle,
    output logic               Freq_err
);

    localparam int unsigned PW = 32;
    localparam int unsigned SW = PW + 1;

    localparam logic signed [PW-1:0] PI_P      = PW'(PI_Q);
    localparam logic signed [PW-1:0] PI_N      = PW'(-PI_Q);
    localparam logic signed [SW-1:0] PI_S      = SW'(PI_Q);
    localparam logic signed [SW-1:0] NEG_PI_S  = SW'(-PI_Q);
    localparam logic signed [SW-1:0] TWO_PI_S  = SW'(TWO_PI_Q);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic                  tick_c;
    logic signed [PW-1:0]  freq_r;
    logic                  sync_pend;
    logic signed [PW-1:0]  freq_lim_c;
    logic                  freq_oor_c;
    logic signed [SW-1:0]  sum_c;
    logic signed [PW-1:0]  phase_nxt_c;
    logic                  cycle_nxt_c;

    always_ff @(posedge Sys_clk or posedge Phs_rst) begin
        if (Phs_rst) state <= IDLE;
        else         state <= state_nxt;
    end

    // IDLE only leaves on the first frequency load; RUN is terminal until reset
    always_comb begin
        state_nxt = state;
        tick_c    = 1'b0;
        case (state)
            IDLE: if (Freq_ld) state_nxt = RUN;
            RUN:  tick_c = Phs_ce;
            default: state_nxt = IDLE;
        endcase
    end

    // Clamp the incoming increment so one wrap per tick is always enough
    always_comb begin
        freq_lim_c = Freq;
        freq_oor_c = 1'b0;
        if (Freq > PI_P) begin
            freq_lim_c = PI_P;
            freq_oor_c = 1'b1;
        end else if (Freq < PI_N) begin
            freq_lim_c = PI_N;
            freq_oor_c = 1'b1;
        end
    end

    always_comb begin
        sum_c       = SW'({Phase[PW-1], Phase}) + SW'({freq_r[PW-1], freq_r});
        phase_nxt_c = PW'(sum_c);
        cycle_nxt_c = 1'b0;
        if (sync_pend || Sync) begin
            phase_nxt_c = '0;
            cycle_nxt_c = 1'b1;
        end else if (sum_c >= PI_S) begin
            phase_nxt_c = PW'(sum_c - TWO_PI_S);
            cycle_nxt_c = 1'b1;
        end else if (sum_c < NEG_PI_S) begin
            phase_nxt_c = PW'(sum_c + TWO_PI_S);
            cycle_nxt_c = 1'b1;
        end
    end

    always_ff @(posedge Sys_clk or posedge Phs_rst) begin
        if (Phs_rst) begin
            Phase     <= '0;
            Phase_vld <= 1'b0;
            Cycle     <= 1'b0;
            Freq_err  <= 1'b0;
            freq_r    <= '0;
            sync_pend <= 1'b0;
        end else begin
            Phase_vld <= tick_c;
            Cycle     <= tick_c && cycle_nxt_c;
            if (tick_c) Phase <= phase_nxt_c;
            // A coincident tick still sees the old increment
            if (Freq_ld) begin
                freq_r   <= freq_lim_c;
                Freq_err <= freq_oor_c;
            end
            if (tick_c)    sync_pend <= 1'b0;
            else if (Sync) sync_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_phase_accumulator.sv
// Directed-vector bench for phase_accumulator; expected updates are queued
// by the stimulus and retired by an independent output monitor.
module tb_phase_accumulator;

    localparam int PI_Q = 205887;

    logic               Sys_clk = 1'b0;
    logic               Phs_rst = 1'b1;
    logic               Phs_ce  = 1'b0;
    logic signed [31:0] Freq    = '0;
    logic               Freq_ld = 1'b0;
    logic               Sync    = 1'b0;
    logic signed [31:0] Phase;
    logic               Phase_vld;
    logic               Cycle;
    logic               Freq_err;

    typedef struct {
        logic signed [31:0] ph;
        logic               cy;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    phase_accumulator #(.PI_Q(PI_Q), .TWO_PI_Q(2 * PI_Q)) dut (
        .Sys_clk   (Sys_clk),
        .Phs_rst   (Phs_rst),
        .Phs_ce    (Phs_ce),
        .Freq      (Freq),
        .Freq_ld   (Freq_ld),
        .Sync      (Sync),
        .Phase     (Phase),
        .Phase_vld (Phase_vld),
        .Cycle     (Cycle),
        .Freq_err  (Freq_err)
    );

    always #5 Sys_clk = ~Sys_clk;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // One clock of stimulus; an accepted tick queues its expected result
    task automatic cyc(input logic ce, input logic ld, input logic sy,
                       input logic signed [31:0] f, input logic acc,
                       input logic signed [31:0] eph, input logic ecy);
        exp_t e;
        Phs_ce  = ce;
        Freq_ld = ld;
        Sync    = sy;
        Freq    = f;
        if (acc) begin
            e.ph = eph;
            e.cy = ecy;
            exp_q.push_back(e);
        end
        @(posedge Sys_clk);
        #1;
        Phs_ce  = 1'b0;
        Freq_ld = 1'b0;
        Sync    = 1'b0;
    endtask

    task automatic tick(input logic signed [31:0] eph, input logic ecy);
        cyc(1'b1, 1'b0, 1'b0, 0, 1'b1, eph, ecy);
    endtask

    task automatic load(input logic signed [31:0] f);
        cyc(1'b0, 1'b1, 1'b0, f, 1'b0, 0, 1'b0);
    endtask

    task automatic drain();
        int budget = 20;
        while (exp_q.size() != 0 && budget > 0) begin
            @(posedge Sys_clk);
            budget--;
        end
        #1;
        check("queue_drained", 32'(exp_q.size()), 0);
    endtask

    // Monitor: retire one expected entry per Phase_vld pulse
    initial begin
        exp_t e;
        forever begin
            @(negedge Sys_clk);
            if (!Phs_rst) begin
                if (Phase_vld) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_vld: got Phase_vld=1 Phase=%0d, expected no update", Phase);
                    end else begin
                        e = exp_q.pop_front();
                        if (Phase !== e.ph || Cycle !== e.cy) begin
                            n_err++;
                            $display("FAIL update: got Phase=%0d Cycle=%0b, expected Phase=%0d Cycle=%0b",
                                     Phase, Cycle, e.ph, e.cy);
                        end
                    end
                end else if (Cycle) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL cycle_no_vld: got Cycle=1 with Phase_vld=0, expected 0");
                end
            end
        end
    end

    initial begin
        repeat (2) @(posedge Sys_clk);
        #1;
        check("rst_phase", Phase, 0);
        check("rst_vld", 32'(Phase_vld), 0);
        check("rst_cycle", 32'(Cycle), 0);
        check("rst_ferr", 32'(Freq_err), 0);
        Phs_rst = 1'b0;
        @(posedge Sys_clk);
        #1;

        // Ticks before any load are ignored
        tick(0, 1'b0);
        void'(exp_q.pop_back());
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);

        // Positive ramp with wrap on the 4th tick
        load(65536);
        check("ferr_in_range", 32'(Freq_err), 0);
        tick(65536, 1'b0);
        tick(131072, 1'b0);
        tick(196608, 1'b0);
        tick(-149630, 1'b1);
        drain();
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
        check("phase_hold", Phase, -149630);

        // Sync between ticks, then negative ramp
        cyc(1'b0, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0);
        tick(0, 1'b1);
        load(-65536);
        tick(-65536, 1'b0);
        tick(-131072, 1'b0);
        tick(-196608, 1'b0);
        tick(149630, 1'b1);

        // Over-range positive load clamps to +PI_Q
        load(262144);
        drain();
        check("ferr_pos_oor", 32'(Freq_err), 1);
        cyc(1'b1, 1'b0, 1'b1, 0, 1'b1, 0, 1'b1);
        tick(-PI_Q, 1'b1);
        // Over-range negative clamps to -PI_Q: -PI_Q + -PI_Q wraps to 0
        load(-300000);
        drain();
        check("ferr_neg_oor", 32'(Freq_err), 1);
        tick(0, 1'b1);
        load(1000);
        drain();
        check("ferr_cleared", 32'(Freq_err), 0);

        // Load coincident with tick applies from the next tick
        cyc(1'b1, 1'b0, 1'b1, 0, 1'b1, 0, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 2000, 1'b1, 1000, 1'b0);
        tick(3000, 1'b0);

        // Boundaries: sum == PI_Q wraps, sum == -PI_Q does not
        load(PI_Q);
        cyc(1'b1, 1'b0, 1'b1, 0, 1'b1, 0, 1'b1);
        tick(-PI_Q, 1'b1);
        tick(0, 1'b0);
        load(-PI_Q);
        drain();
        check("ferr_edge", 32'(Freq_err), 0);
        tick(-PI_Q, 1'b0);

        // Repeated sync is a single request
        cyc(1'b0, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0);
        tick(0, 1'b1);
        tick(-PI_Q, 1'b0);
        drain();

        // Async reset mid-run with a sync pending
        cyc(1'b0, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0);
        #3;
        Phs_rst = 1'b1;
        #1;
        check("async_rst_phase", Phase, 0);
        @(posedge Sys_clk);
        #1;
        Phs_rst = 1'b0;
        repeat (2) cyc(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
        check("post_rst_phase", Phase, 0);
        load(1000);
        tick(1000, 1'b0);
        tick(2000, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no completion, expected finish before 50000");
        $fatal(1, "timeout");
    end

endmodule
